// File: rtl/int_wb_pkg.sv
// Shared constants, write-back request type and hazard helper for the
// integer register-file write-back scheduler.
package int_wb_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = $clog2(NREGS);

    typedef struct packed {
        logic            valid;
        logic [AW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_req_t;

    // x0 is hard-wired, so it can never be the subject of a hazard.
    function automatic logic reg_hazard(input logic [NREGS-1:0] sb,
                                        input logic [AW-1:0]    idx,
                                        input logic             used);
        return used && (idx != '0) && sb[idx];
    endfunction

endpackage

// File: rtl/int_scoreboard.sv
// Pending-APU-write bitmap with set/clear ports and a three-index hazard lookup.
// The lookup reads only the registered bitmap.
module int_scoreboard
    import int_wb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             set_en,
    input  logic [AW-1:0]    set_idx,
    input  logic             clr_en,
    input  logic [AW-1:0]    clr_idx,
    input  logic [AW-1:0]    rs1,
    input  logic             rs1_used,
    input  logic [AW-1:0]    rs2,
    input  logic             rs2_used,
    input  logic [AW-1:0]    rd,
    input  logic             rd_used,
    output logic             hazard,
    output logic [NREGS-1:0] busy_mask
);

    logic [NREGS-1:0] sb_q, sb_d;

    always_comb begin
        sb_d = sb_q;
        if (clr_en) begin
            sb_d[clr_idx] = 1'b0;
        end
        if (set_en && (set_idx != '0)) begin
            sb_d[set_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    assign hazard = reg_hazard(sb_q, rs1, rs1_used)
                  | reg_hazard(sb_q, rs2, rs2_used)
                  | reg_hazard(sb_q, rd,  rd_used);

    assign busy_mask = sb_q;

endmodule

// File: rtl/int_wb_scheduler.sv
// Shares the integer register-file write port between the ALU and the APU,
// with a one-entry skid buffer and an APU destination scoreboard.
// Defining INT_WB_PERF_EN adds the stall_count output.
module int_wb_scheduler
    import int_wb_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             issue_valid,
    input  logic [AW-1:0]    issue_rs1,
    input  logic [AW-1:0]    issue_rs2,
    input  logic             issue_rs1_used,
    input  logic             issue_rs2_used,
    input  logic [AW-1:0]    issue_rd,
    input  logic             issue_wr,
    input  logic             issue_apu,
    output logic             issue_ready,
    input  logic             alu_wb_valid,
    input  logic [AW-1:0]    alu_wb_rd,
    input  logic [XLEN-1:0]  alu_wb_data,
    input  logic             apu_result_valid,
    input  logic [AW-1:0]    apu_result_rd,
    input  logic [XLEN-1:0]  apu_result_data,
    output logic             apu_result_ready,
    output logic             rf_we,
    output logic [AW-1:0]    rf_waddr,
    output logic [XLEN-1:0]  rf_wdata,
`ifdef INT_WB_PERF_EN
    output logic [NREGS-1:0] busy_mask,
    output logic [31:0]      stall_count
`else
    output logic [NREGS-1:0] busy_mask
`endif
);

    // Handshakes: a transfer happens on a cycle where valid & ready are both
    // high; valid never depends on ready, and ready is combinational here.
    logic          hazard;
    logic          issue_fire;
    logic          apu_fire;
    logic          sb_set;
    logic          clr_en;
    logic [AW-1:0] clr_idx;
    wb_req_t       buf_q, buf_d;
    wb_req_t       wr;

    assign issue_ready      = !reset && !hazard;
    assign apu_result_ready = !reset && !buf_q.valid;
    assign issue_fire       = issue_valid && issue_ready;
    assign apu_fire         = apu_result_valid && apu_result_ready;
    assign sb_set           = issue_fire && issue_apu && issue_wr;

    // Port priority: ALU, then skid buffer, then direct APU result.
    always_comb begin
        buf_d   = buf_q;
        wr      = '0;
        clr_en  = 1'b0;
        clr_idx = '0;
        if (alu_wb_valid) begin
            wr.valid = (alu_wb_rd != '0);
            wr.rd    = alu_wb_rd;
            wr.data  = alu_wb_data;
            if (apu_fire && (apu_result_rd != '0)) begin
                buf_d.valid = 1'b1;
                buf_d.rd    = apu_result_rd;
                buf_d.data  = apu_result_data;
            end
        end else if (buf_q.valid) begin
            wr      = buf_q;
            buf_d   = '0;
            clr_en  = 1'b1;
            clr_idx = buf_q.rd;
        end else if (apu_fire) begin
            wr.valid = (apu_result_rd != '0);
            wr.rd    = apu_result_rd;
            wr.data  = apu_result_data;
            clr_en   = 1'b1;
            clr_idx  = apu_result_rd;
        end
        if (reset) begin
            wr     = '0;
            clr_en = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

    assign rf_we    = wr.valid;
    assign rf_waddr = wr.rd;
    assign rf_wdata = wr.data;

    int_scoreboard u_scoreboard (
        .clock     (clock),
        .reset     (reset),
        .set_en    (sb_set),
        .set_idx   (issue_rd),
        .clr_en    (clr_en),
        .clr_idx   (clr_idx),
        .rs1       (issue_rs1),
        .rs1_used  (issue_rs1_used),
        .rs2       (issue_rs2),
        .rs2_used  (issue_rs2_used),
        .rd        (issue_rd),
        .rd_used   (issue_wr),
        .hazard    (hazard),
        .busy_mask (busy_mask)
    );

`ifdef INT_WB_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (issue_valid && !issue_ready && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
`endif

endmodule
